// File: rtl/axo_dbg_pkg.sv
// Shared constants and types for the UART debug bridge: command and response
// codes, the control FSM state encoding and the argument-length helper.
package axo_dbg_pkg;

    localparam logic [7:0] CMD_PING  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam logic [7:0] RSP_PING  = 8'h55;
    localparam logic [7:0] RSP_ACK   = 8'hAA;
    localparam logic [7:0] RSP_ERR   = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARGS,
        ST_BUS,
        ST_RESP
    } dbg_state_t;

    // Index of the final argument byte: addr+data for a write, addr only for a read.
    function automatic logic [2:0] last_arg_idx(input logic is_write);
        return is_write ? 3'd7 : 3'd3;
    endfunction

endpackage

// File: rtl/axo_uart_dbg_bridge_if.sv
// Peripheral bus seen from the debug bridge: one 32-bit word access at a time,
// completed by bus_ready.
interface axo_uart_dbg_bridge_if;

    logic [31:0] bus_addr;
    logic        bus_re;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_addr,
        output bus_re,
        output bus_we,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ready
    );

    modport slave (
        input  bus_addr,
        input  bus_re,
        input  bus_we,
        input  bus_wdata,
        output bus_rdata,
        output bus_ready
    );

endinterface

// File: rtl/axo_dbg_tx_ser.sv
// Response serializer: holds one to four bytes and hands them out LSB-first,
// one per tx handshake, pulsing done when the last byte is taken.
module axo_dbg_tx_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_cnt,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [31:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        tx_hs;

    always_comb begin
        // NOTE: every signal written here gets its default first, so no path can infer a latch.
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tx_hs   = (cnt_q != 3'd0) && tx_ready;
        done    = tx_hs && (cnt_q == 3'd1);

        if (load) begin
            shift_d = load_data;
            cnt_d   = load_cnt;
        end else if (tx_hs) begin
            // Zero-fill so tx_data idles at 0 once the response is drained.
            shift_d = {8'h00, shift_q[31:8]};
            cnt_d   = cnt_q - 3'd1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_valid = (cnt_q != 3'd0);
    assign tx_data  = shift_q[7:0];

endmodule

// File: rtl/axo_uart_dbg_bridge.sv
// UART debug bridge: parses PING/WRITE/READ packets from the rx byte stream,
// runs one 32-bit bus access per packet and streams the response to tx.
module axo_uart_dbg_bridge
    import axo_dbg_pkg::*;
#(
    parameter int TIMEOUT = 100000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    axo_uart_dbg_bridge_if.master         bus,
    output logic                          busy,
    output logic                          err_pulse
);

    localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    dbg_state_t     state_q, state_d;
    logic           is_wr_q, is_wr_d;
    logic [2:0]     arg_cnt_q, arg_cnt_d;
    logic [63:0]    args_q, args_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
    logic           rx_ready_q, rx_ready_d;

    logic           rx_hs;
    logic           ser_load;
    logic [31:0]    ser_data;
    logic [2:0]     ser_cnt;
    logic           ser_done;
    logic           in_bus;

    assign rx_hs = rx_valid && rx_ready_q;

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        arg_cnt_d = arg_cnt_q;
        args_d    = args_q;
        tmo_d     = '0;
        err_d     = 1'b0;
        ser_load  = 1'b0;
        ser_data  = '0;
        ser_cnt   = 3'd1;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_hs) begin
                    arg_cnt_d = 3'd0;
                    case (rx_data)
                        CMD_PING: begin
                            ser_load = 1'b1;
                            ser_data = {24'h0, RSP_PING};
                            state_d  = ST_RESP;
                        end
                        CMD_WRITE: begin
                            is_wr_d = 1'b1;
                            state_d = ST_ARGS;
                        end
                        CMD_READ: begin
                            is_wr_d = 1'b0;
                            state_d = ST_ARGS;
                        end
                        default: begin
                            ser_load = 1'b1;
                            ser_data = {24'h0, RSP_ERR};
                            err_d    = 1'b1;
                            state_d  = ST_RESP;
                        end
                    endcase
                end
            end

            ST_ARGS: begin
                // A byte arriving in the cycle the counter would expire takes priority.
                if (rx_hs) begin
                    args_d[{arg_cnt_q, 3'b000} +: 8] = rx_data;
                    if (arg_cnt_q == last_arg_idx(is_wr_q)) begin
                        state_d = ST_BUS;
                    end else begin
                        arg_cnt_d = arg_cnt_q + 3'd1;
                    end
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_BUS: begin
                if (bus.bus_ready) begin
                    ser_load = 1'b1;
                    ser_data = is_wr_q ? {24'h0, RSP_ACK} : bus.bus_rdata;
                    ser_cnt  = is_wr_q ? 3'd1 : 3'd4;
                    state_d  = ST_RESP;
                end
            end

            ST_RESP: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ARGS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_wr_q    <= 1'b0;
            arg_cnt_q  <= '0;
            args_q     <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            arg_cnt_q  <= arg_cnt_d;
            args_q     <= args_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    axo_dbg_tx_ser u_tx_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .load_data (ser_data),
        .load_cnt  (ser_cnt),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (ser_done)
    );

    // Bus strobes decode straight from the state flops, so an async reset drops them at once.
    assign in_bus        = (state_q == ST_BUS);
    assign bus.bus_re    = in_bus && !is_wr_q;
    assign bus.bus_we    = in_bus && is_wr_q;
    assign bus.bus_addr  = in_bus ? (args_q[31:0] & 32'hFFFF_FFFC) : 32'h0;
    assign bus.bus_wdata = (in_bus && is_wr_q) ? args_q[63:32] : 32'h0;

    assign rx_ready  = rx_ready_q;
    assign busy      = (state_q != ST_IDLE);
    assign err_pulse = err_q;

endmodule

// File: tb/tb_axo_uart_dbg_bridge.sv
// Self-checking bench for axo_uart_dbg_bridge: directed packets with literal
// expectations, then randomized packets against a packet-level reference model.
module tb_axo_uart_dbg_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        err_pulse;

    axo_uart_dbg_bridge_if bus_if ();

    axo_uart_dbg_bridge #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .bus       (bus_if),
        .busy      (busy),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_op_t;

    bus_op_t     exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rdata[$];

    int checks_total  = 0;
    int checks_passed = 0;
    int exp_err  = 0;
    int seen_err = 0;
    int tx_count = 0;
    int bus_acc  = 0;
    int force_lat = -1;
    int force_txr = -1;
    int last_cycles = 0;
    logic [31:0] last_addr  = '0;
    logic [31:0] last_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: what one packet must produce on the bus and on tx.
    task automatic expect_packet(input logic [7:0] cmd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] rdata);
        bus_op_t op;
        case (cmd)
            8'h00: exp_tx.push_back(8'h55);
            8'h01: begin
                op.wr = 1'b1; op.addr = {addr[31:2], 2'b00}; op.data = data;
                exp_bus.push_back(op);
                exp_tx.push_back(8'hAA);
            end
            8'h02: begin
                op.wr = 1'b0; op.addr = {addr[31:2], 2'b00}; op.data = 32'h0;
                exp_bus.push_back(op);
                exp_rdata.push_back(rdata);
                for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
            end
            default: begin
                exp_tx.push_back(8'hEE);
                exp_err++;
            end
        endcase
    endtask

    function automatic int rgap();
        return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    endfunction

    // Entered just after a posedge; returns just after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit hs;
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        rx_data  = b;
        rx_valid = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 500) begin
            @(negedge clk);
            hs = rx_ready;
            @(posedge clk);
            n++;
        end
        if (!hs) check("rx_handshake_timeout", 64'(n), 64'(0));
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], (gap < 0) ? rgap() : gap);
    endtask

    task automatic send_packet(input logic [7:0] cmd, input logic [31:0] addr,
                               input logic [31:0] data, input int gap);
        send_byte(cmd, (gap < 0) ? rgap() : gap);
        if (cmd == 8'h01 || cmd == 8'h02) send_word(addr, gap);
        if (cmd == 8'h01) send_word(data, gap);
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_tx.size() == 0 && exp_bus.size() == 0 && !busy) && n < 2000);
        if (n >= 2000) check("drain_timeout", 64'(exp_tx.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Monitor / bus slave / tx sink, all working at the negative edge.
    initial begin : monitor
        bit           stall = 0, prev_err = 0, active_prev = 0, ready_prev = 0;
        logic [7:0]   stall_data = '0;
        logic [65:0]  cap = '0;
        int           lat = 0, cnt = 0, post_rst = 0;
        bit           txr, act;
        bus_op_t      op;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 0; prev_err = 0; active_prev = 0; ready_prev = 0; post_rst = 0;
                bus_if.bus_ready = 1'b0;
                tx_ready = 1'b0;
            end else begin
                if (post_rst < 4) post_rst++;
                check("re_we_exclusive", 64'(bus_if.bus_re && bus_if.bus_we), 64'(0));
                if (post_rst >= 2) check("idle_accepts_rx", 64'(busy || rx_ready), 64'(1));
                check("busy_while_active",
                      64'(!(bus_if.bus_re || bus_if.bus_we || tx_valid) || (busy && !rx_ready)), 64'(1));
                if (err_pulse) begin
                    seen_err++;
                    check("err_single_cycle", 64'(prev_err), 64'(0));
                end
                prev_err = err_pulse;

                if (stall) begin
                    check("tx_hold_valid", 64'(tx_valid), 64'(1));
                    check("tx_hold_data", 64'(tx_data), 64'(stall_data));
                end
                txr = (force_txr >= 0) ? (force_txr != 0) : ($urandom_range(0, 3) != 0);
                tx_ready = txr;
                if (tx_valid && txr) begin
                    tx_count++;
                    check("tx_byte_expected", 64'(exp_tx.size() > 0), 64'(1));
                    if (exp_tx.size() > 0) check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
                end
                stall      = tx_valid && !txr;
                stall_data = tx_data;

                act = bus_if.bus_re || bus_if.bus_we;
                if (ready_prev) begin
                    check("bus_deassert", 64'(act), 64'(0));
                    ready_prev = 0;
                    active_prev = 0;
                    bus_if.bus_ready = 1'b0;
                end else if (act) begin
                    if (!active_prev) begin
                        bus_acc++;
                        check("bus_access_expected", 64'(exp_bus.size() > 0), 64'(1));
                        bus_if.bus_rdata = $urandom;
                        if (exp_bus.size() > 0) begin
                            op = exp_bus.pop_front();
                            check("bus_dir", 64'(bus_if.bus_we), 64'(op.wr));
                            check("bus_addr", 64'(bus_if.bus_addr), 64'(op.addr));
                            if (op.wr) check("bus_wdata", 64'(bus_if.bus_wdata), 64'(op.data));
                            else if (exp_rdata.size() > 0) bus_if.bus_rdata = exp_rdata.pop_front();
                        end
                        cap = {bus_if.bus_re, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata};
                        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
                        cnt = 0;
                        last_addr  = bus_if.bus_addr;
                        last_wdata = bus_if.bus_wdata;
                    end else begin
                        check("bus_stable",
                              64'({bus_if.bus_re, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata} == cap), 64'(1));
                    end
                    bus_if.bus_ready = (cnt == lat);
                    ready_prev  = bus_if.bus_ready;
                    cnt++;
                    last_cycles = cnt;
                    active_prev = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", checks_passed, checks_total);
        $fatal(1);
    end

    initial begin : main
        int t0, b0, e0, k, n;
        logic [7:0] cmd;
        logic [31:0] a, d;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b0;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = '0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_rx_ready", 64'(rx_ready), 64'(0));
        check("rst_tx", 64'({tx_valid, tx_data}), 64'(0));
        check("rst_bus", 64'({bus_if.bus_re, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata}), 64'(0));
        check("rst_busy_err", 64'({busy, err_pulse}), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: PING
        t0 = tx_count; b0 = bus_acc;
        exp_tx.push_back(8'h55);
        send_byte(8'h00, 0);
        wait_drain();
        check("t1_tx_count", 64'(tx_count - t0), 64'(1));
        check("t1_no_bus", 64'(bus_acc - b0), 64'(0));
        check("t1_busy_low", 64'(busy), 64'(0));

        // 2: WRITE, ready after 3 cycles
        expect_packet(8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        check("t2_model_addr", 64'(exp_bus[0].addr), 64'h10);
        check("t2_model_rsp", 64'(exp_tx[0]), 64'hAA);
        force_lat = 3;
        send_packet(8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        wait_drain();
        force_lat = -1;
        check("t2_we_cycles", 64'(last_cycles), 64'(4));
        check("t2_addr", 64'(last_addr), 64'h10);
        check("t2_wdata", 64'(last_wdata), 64'hDEAD_BEEF);

        // 3: READ with unaligned address
        expect_packet(8'h02, 32'h0000_0013, 32'h0, 32'h1234_5678);
        check("t3_model_bytes", 64'({exp_tx[0], exp_tx[1], exp_tx[2], exp_tx[3]}), 64'h7856_3412);
        send_packet(8'h02, 32'h0000_0013, 32'h0, 0);
        wait_drain();
        check("t3_addr", 64'(last_addr), 64'h10);

        // 4: unknown command then PING
        e0 = seen_err;
        exp_tx.push_back(8'hEE);
        exp_err++;
        send_byte(8'h7F, 0);
        wait_drain();
        check("t4_err_once", 64'(seen_err - e0), 64'(1));
        exp_tx.push_back(8'h55);
        send_byte(8'h00, 0);
        wait_drain();

        // 5: inter-byte timeout
        t0 = tx_count; b0 = bus_acc; e0 = seen_err;
        exp_err++;
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        k = 0;
        do begin
            @(posedge clk);
            k++;
            #1;
        end while (!err_pulse && k < 30);
        check("t5_tmo_cycles", 64'(k), 64'(16));
        repeat (20 - k) @(posedge clk);
        #1;
        check("t5_no_tx", 64'(tx_count - t0), 64'(0));
        check("t5_no_bus", 64'(bus_acc - b0), 64'(0));
        check("t5_busy_low", 64'(busy), 64'(0));
        exp_tx.push_back(8'h55);
        send_byte(8'h00, 0);
        wait_drain();
        // Byte arriving in the expiry cycle keeps the packet alive.
        e0 = seen_err;
        expect_packet(8'h01, 32'h0000_0106, 32'hCAFE_F00D, 32'h0);
        send_packet(8'h01, 32'h0000_0106, 32'hCAFE_F00D, TMO - 1);
        wait_drain();
        check("t5_edge_no_err", 64'(seen_err - e0), 64'(0));
        check("t5_edge_addr", 64'(last_addr), 64'h104);

        // 6: tx back-pressure during a READ response
        force_txr = 0;
        expect_packet(8'h02, 32'h0000_0044, 32'h0, 32'hA1B2_C3D4);
        send_packet(8'h02, 32'h0000_0044, 32'h0, 0);
        n = 0;
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check("t6_stalled_valid", 64'(tx_valid), 64'(1));
        check("t6_stalled_data", 64'(tx_data), 64'hD4);
        force_txr = -1;
        wait_drain();

        // 6b: reset in the middle of a bus write
        force_lat = 100000;
        expect_packet(8'h01, 32'h0000_0200, 32'h5555_AAAA, 32'h0);
        send_packet(8'h01, 32'h0000_0200, 32'h5555_AAAA, 0);
        n = 0;
        while (!bus_if.bus_we && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_we_seen", 64'(bus_if.bus_we), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_we_drop", 64'(bus_if.bus_we), 64'(0));
        check("t6_rst_idle", 64'({busy, tx_valid}), 64'(0));
        exp_tx.delete();
        exp_bus.delete();
        exp_rdata.delete();
        force_lat = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_tx.push_back(8'h55);
        send_byte(8'h00, 0);
        wait_drain();
        check("t6_post_rst_idle", 64'(busy), 64'(0));

        // Randomized packets against the model
        for (int p = 0; p < 150; p++) begin
            k = $urandom_range(0, 9);
            a = $urandom;
            d = $urandom;
            if (k < 2)       cmd = 8'h00;
            else if (k < 5)  cmd = 8'h01;
            else if (k < 8)  cmd = 8'h02;
            else             cmd = 8'(3 + $urandom_range(0, 252));
            if (k == 9) begin
                cmd = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02;
                exp_err++;
                send_byte(cmd, rgap());
                n = $urandom_range(0, (cmd == 8'h01) ? 7 : 3);
                for (int i = 0; i < n; i++) send_byte(8'($urandom), rgap());
                repeat (20) @(posedge clk);
                #1;
            end else begin
                expect_packet(cmd, a, d, $urandom);
                send_packet(cmd, a, d, -1);
            end
        end
        wait_drain();
        check("end_tx_queue_empty", 64'(exp_tx.size()), 64'(0));
        check("end_bus_queue_empty", 64'(exp_bus.size()), 64'(0));
        check("end_err_count", 64'(seen_err), 64'(exp_err));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
